// File: rtl/recip_result_reader.sv
// Reads reciprocal-counter TDC results through a valid/ack handshake and
// serialises each one as a checksummed byte frame on a valid/ready stream.
module recip_result_reader #(
  parameter int         COARSE_WIDTH = 24,
  parameter int         MIN_COARSE   = 1,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic                    clk_fast,
  input  logic                    rst,
  input  logic                    tdc_valid_fast,
  input  logic [COARSE_WIDTH-1:0] tdc_coarse_fast,
  input  logic [7:0]              tdc_fine_raw_fast,
  output logic                    tdc_ack_fast,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              drop_count,
  output logic                    busy
);

  localparam int                      NB       = COARSE_WIDTH / 8;
  localparam logic [2:0]              LAST_IDX = 3'(NB + 3);
  localparam logic [COARSE_WIDTH-1:0] MIN_C    = COARSE_WIDTH'(MIN_COARSE);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state, state_nxt;
  logic                    armed;
  logic [7:0]              seq;
  logic [COARSE_WIDTH-1:0] coarse_p1;
  logic [7:0]              fine_p1;
  logic [2:0]              idx, idx_nxt;
  logic                    accept, drop, xfer, last_xfer;
  logic [7:0]              frame [8];
  logic [7:0]              chk;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Frame image built from the latched result; index 0 is the header.
  always_comb begin
    chk = seq ^ fine_p1;
    for (int b = 0; b < NB; b++) begin
      chk = chk ^ coarse_p1[COARSE_WIDTH-1-8*b -: 8];
    end
    for (int k = 0; k < 8; k++) begin
      frame[k] = 8'h00;
    end
    frame[0] = HEADER;
    frame[1] = seq;
    for (int b = 0; b < NB; b++) begin
      frame[3'(2 + b)] = coarse_p1[COARSE_WIDTH-1-8*b -: 8];
    end
    frame[3'(NB + 2)] = fine_p1;
    frame[LAST_IDX]   = chk;
  end

  // Next state and handshake decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    drop      = 1'b0;
    xfer      = 1'b0;
    last_xfer = 1'b0;
    idx_nxt   = idx + 3'd1;
    case (state)
      IDLE: begin
        if (tdc_valid_fast && armed && !rst) begin
          accept = 1'b1;
          drop   = (tdc_coarse_fast < MIN_C);
          if (!drop) begin
            state_nxt = SEND;
          end
        end
      end
      SEND: begin
        xfer      = out_valid && out_ready;
        last_xfer = xfer && (idx == LAST_IDX);
        if (last_xfer) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tdc_ack_fast = accept;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage p1: latched result, frame sequencing and counters
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      armed      <= 1'b0;
      seq        <= 8'h00;
      drop_count <= 8'h00;
      coarse_p1  <= '0;
      fine_p1    <= 8'h00;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      idx        <= 3'd0;
    end else begin
      // A result still pending after ack must be seen low before re-arming.
      if (!tdc_valid_fast) begin
        armed <= 1'b1;
      end else if (accept) begin
        armed <= 1'b0;
      end

      if (accept) begin
        coarse_p1 <= tdc_coarse_fast;
        fine_p1   <= tdc_fine_raw_fast;
        if (drop) begin
          drop_count <= sat_inc8(drop_count);
        end else begin
          out_data  <= HEADER;
          out_valid <= 1'b1;
          idx       <= 3'd0;
        end
      end

      if (last_xfer) begin
        out_valid <= 1'b0;
        out_data  <= 8'h00;
        seq       <= seq + 8'd1;
      end else if (xfer) begin
        idx      <= idx_nxt;
        out_data <= frame[idx_nxt];
      end
    end
  end

endmodule
